// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi
//   Multi-channel programmable pulse generator. Each channel runs its own
//   IDLE/RUN state machine. It produces a pulse train with a programmable period
//   and high time, in either periodic or one-shot mode. Each channel also
//   produces an end-of-period tick.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   enable   [CHANNELS]        per-channel run enable (level)
//   oneshot  [CHANNELS]        0 = periodic, 1 = one-shot (sampled in IDLE)
//   start    [CHANNELS]        one-shot trigger strobe
//   period   [CHANNELS*CNT_W]  per-channel period, channel i at [i*CNT_W +: CNT_W]
//   width    [CHANNELS*CNT_W]  per-channel high time, same packing
//   pulse    [CHANNELS]        registered pulse outputs
//   tick     [CHANNELS]        registered strobe on the last cycle of each period
//   busy     [CHANNELS]        channel is in RUN
module pulse_gen_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS*CNT_W-1:0] width,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A programmed period of 0 behaves as a period of 1.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
    return (p == '0) ? ONE : p;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, state_nxt;
    logic             os_mode, os_mode_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act_p, act_p_nxt;
    logic [CNT_W-1:0] act_w, act_w_nxt;
    logic [CNT_W-1:0] cfg_p, cfg_w;
    logic             pulse_q, tick_q, busy_q;
    logic             pulse_nxt, tick_nxt, busy_nxt;
    logic             run_nxt;

    assign cfg_p = period[i*CNT_W +: CNT_W];
    assign cfg_w = width[i*CNT_W +: CNT_W];

    always_comb begin
      state_nxt   = state;
      os_mode_nxt = os_mode;
      cnt_nxt     = cnt;
      act_p_nxt   = act_p;
      act_w_nxt   = act_w;
      case (state)
        IDLE: begin
          // The mode is latched here, so toggling oneshot during RUN has no effect.
          if (enable[i] && (!oneshot[i] || start[i])) begin
            state_nxt   = RUN;
            os_mode_nxt = oneshot[i];
            cnt_nxt     = '0;
            act_p_nxt   = cfg_p;
            act_w_nxt   = cfg_w;
          end
        end
        RUN: begin
          if (!enable[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == eff_period(act_p) - ONE) begin
            cnt_nxt = '0;
            if (os_mode) begin
              state_nxt = IDLE;
            end else begin
              // Config is reloaded only at a period boundary, so a period is never truncated.
              act_p_nxt = cfg_p;
              act_w_nxt = cfg_w;
            end
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // The outputs are computed from the next-state values. This lets them appear
    // in the cycle right after the load edge and still come straight from flops.
    assign run_nxt   = (state_nxt == RUN);
    assign busy_nxt  = run_nxt;
    assign pulse_nxt = run_nxt && (cnt_nxt < act_w_nxt);
    assign tick_nxt  = run_nxt && (cnt_nxt == eff_period(act_p_nxt) - ONE);

    // ---- register stage: state, counters and outputs ----
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= IDLE;
        os_mode <= 1'b0;
        cnt     <= '0;
        act_p   <= '0;
        act_w   <= '0;
        pulse_q <= 1'b0;
        tick_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state   <= state_nxt;
        os_mode <= os_mode_nxt;
        cnt     <= cnt_nxt;
        act_p   <= act_p_nxt;
        act_w   <= act_w_nxt;
        pulse_q <= pulse_nxt;
        tick_q  <= tick_nxt;
        busy_q  <= busy_nxt;
      end
    end

    assign pulse[i] = pulse_q;
    assign tick[i]  = tick_q;
    assign busy[i]  = busy_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS-1:0]       oneshot;
  logic [CHANNELS-1:0]       start;
  logic [CHANNELS*CNT_W-1:0] period;
  logic [CHANNELS*CNT_W-1:0] width;
  logic [CHANNELS-1:0]       pulse;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pulse_gen_multi #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot), .start(start),
    .period(period), .width(width), .pulse(pulse), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected {pulse,tick,busy} in the n-th cycle (n>=1) after a periodic load
  // with constant period p and width w.
  function automatic logic [2:0] per_exp(input int n, input int p, input int w);
    int pe;
    int c;
    pe = (p == 0) ? 1 : p;
    c  = (n - 1) % pe;
    per_exp = {(c < w), (c == pe - 1), 1'b1};
  endfunction

  task automatic set_cfg(input int ch, input int p, input int w);
    period[ch*CNT_W +: CNT_W] = p[CNT_W-1:0];
    width[ch*CNT_W +: CNT_W]  = w[CNT_W-1:0];
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    reset = 1'b1; enable = '0; oneshot = '0; start = '0; period = '0; width = '0;
    cyc(); cyc();
    total_cnt++;
    if ({pulse, tick, busy} !== '0) $display("FAIL reset_outputs: got pulse=%b tick=%b busy=%b expected all 0", pulse, tick, busy);
    else pass_cnt++;
    reset = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      cyc();
      obs = {|pulse, |tick, |busy};
      total_cnt++;
      if (obs !== 3'b000) $display("FAIL idle_after_reset n=%0d: got %b expected 000", n, obs);
      else pass_cnt++;
    end
  endtask

  task automatic test_compat();
    logic [2:0] obs, exp;
    set_cfg(0, 5, 1); oneshot[0] = 1'b0; enable[0] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      cyc();
      exp = per_exp(n, 5, 1);
      obs = {pulse[0], tick[0], busy[0]};
      total_cnt++;
      if (obs !== exp) $display("FAIL compat ch0 n=%0d: {pulse,tick,busy} got %b expected %b", n, obs, exp);
      else pass_cnt++;
    end
    enable[0] = 1'b0;
    cyc();
    obs = {pulse[0], tick[0], busy[0]};
    total_cnt++;
    if (obs !== 3'b000) $display("FAIL compat_disable ch0: got %b expected 000", obs);
    else pass_cnt++;
  endtask

  task automatic test_config_change();
    logic [2:0] obs, exp;
    set_cfg(1, 8, 3); oneshot[1] = 1'b0; enable[1] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      exp = (n <= 8) ? per_exp(n, 8, 3) : per_exp(n - 8, 4, 2);
      obs = {pulse[1], tick[1], busy[1]};
      total_cnt++;
      if (obs !== exp) $display("FAIL cfg_change ch1 n=%0d: {pulse,tick,busy} got %b expected %b", n, obs, exp);
      else pass_cnt++;
      if (n == 4) set_cfg(1, 4, 2);
    end
    enable[1] = 1'b0;
    cyc();
  endtask

  task automatic test_oneshot();
    logic [2:0] obs, exp;
    set_cfg(2, 6, 6); oneshot[2] = 1'b1; enable[2] = 1'b1; start[2] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      cyc();
      start[2] = 1'b0;
      if (n <= 6)       exp = {1'b1, (n == 6), 1'b1};
      else if (n == 7)  exp = 3'b000;
      else if (n <= 13) exp = {1'b1, (n == 13), 1'b1};
      else              exp = 3'b000;
      obs = {pulse[2], tick[2], busy[2]};
      total_cnt++;
      if (obs !== exp) $display("FAIL oneshot ch2 n=%0d: {pulse,tick,busy} got %b expected %b", n, obs, exp);
      else pass_cnt++;
      if (n == 3 || n == 7) start[2] = 1'b1;
    end
    // A start with enable low must be ignored.
    enable[2] = 1'b0; start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    cyc();
    obs = {pulse[2], tick[2], busy[2]};
    total_cnt++;
    if (obs !== 3'b000) $display("FAIL oneshot_no_enable ch2: got %b expected 000", obs);
    else pass_cnt++;
    oneshot[2] = 1'b0;
  endtask

  task automatic test_boundary();
    int bp[3] = '{0, 4, 4};
    int bw[3] = '{1, 0, 10};
    logic [2:0] obs, exp;
    for (int t = 0; t < 3; t++) begin
      set_cfg(3, bp[t], bw[t]); oneshot[3] = 1'b0; enable[3] = 1'b1;
      for (int n = 1; n <= 8; n++) begin
        cyc();
        exp = per_exp(n, bp[t], bw[t]);
        obs = {pulse[3], tick[3], busy[3]};
        total_cnt++;
        if (obs !== exp) $display("FAIL boundary ch3 p=%0d w=%0d n=%0d: got %b expected %b", bp[t], bw[t], n, obs, exp);
        else pass_cnt++;
      end
      enable[3] = 1'b0;
      cyc();
      obs = {pulse[3], tick[3], busy[3]};
      total_cnt++;
      if (obs !== 3'b000) $display("FAIL boundary_stop ch3 p=%0d w=%0d: got %b expected 000", bp[t], bw[t], obs);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < CHANNELS; c++) set_cfg(c, 5, 2);
    oneshot = '0; enable = '1;
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    total_cnt++;
    if ({pulse, tick, busy} !== '0) $display("FAIL reset_mid: got pulse=%b tick=%b busy=%b expected all 0", pulse, tick, busy);
    else pass_cnt++;
    reset = 1'b0; enable = '0;
    for (int n = 1; n <= 3; n++) begin
      cyc();
      total_cnt++;
      if ({pulse, tick, busy} !== '0) $display("FAIL reset_release n=%0d: got pulse=%b tick=%b busy=%b expected all 0", n, pulse, tick, busy);
      else pass_cnt++;
    end
    // One-shot mode with enable but no start stays IDLE.
    oneshot = '1; enable = '1;
    for (int n = 1; n <= 3; n++) begin
      cyc();
      total_cnt++;
      if ({pulse, busy} !== '0) $display("FAIL oneshot_wait n=%0d: got pulse=%b busy=%b expected 0", n, pulse, busy);
      else pass_cnt++;
    end
    enable = '0; oneshot = '0;
    cyc();
  endtask

  task automatic test_all_channels();
    int ap[4] = '{5, 7, 3, 4};
    int aw[4] = '{2, 3, 1, 4};
    logic [2:0] obs, exp;
    for (int c = 0; c < CHANNELS; c++) set_cfg(c, ap[c], aw[c]);
    oneshot = '0; enable = '1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      for (int c = 0; c < CHANNELS; c++) begin
        exp = (c == 1 && n >= 7) ? 3'b000 : per_exp(n, ap[c], aw[c]);
        obs = {pulse[c], tick[c], busy[c]};
        total_cnt++;
        if (obs !== exp) $display("FAIL all_ch ch%0d n=%0d: {pulse,tick,busy} got %b expected %b", c, n, obs, exp);
        else pass_cnt++;
      end
      if (n == 6) enable[1] = 1'b0;
    end
    enable = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_compat();
    test_config_change();
    test_oneshot();
    test_boundary();
    test_reset_mid();
    test_all_channels();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
- Parametrised, multi-channel successor to the fixed divide-by-5 single-cycle impulse generator.
- Each channel independently produces a programmable-period, programmable-width pulse train, in either free-running (periodic) or one-shot mode.
- Each channel also produces an end-of-period tick for downstream timing.
- Sits in the timing/strobe generation area, feeding enables to counters, samplers and LED/PWM logic.

Parameters:
- CHANNELS, 4, number of independent pulse channels (1..16).
- CNT_W, 16, width of the period/width counters and config fields.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  CHANNELS  per-channel run enable; level-sensitive.
- oneshot  input  CHANNELS  per-channel mode: 0 = periodic, 1 = one-shot; sampled only while the channel is IDLE.
- start  input  CHANNELS  per-channel one-shot trigger; single-cycle strobe, ignored unless enable=1, oneshot=1 and channel IDLE.
- period  input  CHANNELS*CNT_W  per-channel period in cycles; channel i uses bits [i*CNT_W +: CNT_W].
- width  input  CHANNELS*CNT_W  per-channel high time in cycles; same packing.
- pulse  output  CHANNELS  registered pulse outputs.
- tick  output  CHANNELS  registered one-cycle strobe on the last cycle of each period.
- busy  output  CHANNELS  channel is in RUN.

Behaviour:
- Per-channel state machine: IDLE, RUN. Channels are fully independent; no shared state.
- Each channel holds active registers act_p and act_w, plus a count register cnt (CNT_W bits).
- Effective period: Pe = max(act_p, 1), so period 0 behaves as 1.
- Reset:
  - All channels go to IDLE; cnt=0; act_p=0; act_w=0.
  - pulse, tick and busy are all 0 on the cycle after reset is sampled.
  - Reset overrides every other input, including mid-period.
- IDLE → RUN:
  - Periodic: taken at the first edge where enable=1 and oneshot=0.
  - One-shot: taken at an edge where enable=1, oneshot=1 and start=1.
  - On entry: period/width inputs load into act_p/act_w and cnt=0.
- RUN output timing: with load at edge k, Pe=P and act_w=W:
  - pulse=1 in cycles k+1..k+min(W,P), and 0 for the rest of the period.
  - W=0 gives pulse never high. W≥P gives pulse constantly high.
  - tick=1 in the cycle where cnt==Pe-1, i.e. cycle k+P.
  - busy=1 for all RUN cycles.
- Period boundary (cnt==Pe-1):
  - Periodic: cnt wraps to 0, and period/width re-load into act_p/act_w. Config changes therefore take effect only at period boundaries and never truncate a period.
  - One-shot: return to IDLE after the tick cycle. pulse and busy are 0 in the following cycle.
- enable deasserted in RUN:
  - Return to IDLE at that edge; pulse, tick and busy are 0 the next cycle.
  - cnt clears; the partial period is discarded.
- start while in RUN or IDLE-periodic is ignored; start with enable=0 is ignored.
- Re-arm: a start in the cycle right after a one-shot returns to IDLE is accepted, so back-to-back shots leave one idle cycle between them.
- Mode change (oneshot toggled) during RUN has no effect until the channel next passes through IDLE.
- Latency: enable/start to first pulse=1 is 1 cycle (registered outputs).
- Counter arithmetic: unsigned, CNT_W bits. Maximum period is 2^CNT_W-1 cycles; no overflow is possible because cnt never exceeds Pe-1.
- Compatibility: with period=5, width=1 and enable tied high, a channel reproduces a period-5 single-cycle pulse train.

Test Plan:
- Reset, then enable[0]=1, period=5, width=1, oneshot=0 → pulse[0] high 1 cycle in every 5, starting 1 cycle after enable. tick[0] high every 5th cycle, 4 cycles after each pulse.
- Channel 1 period=8, width=3, periodic; at mid-period change to period=4, width=2 → current period completes as 8/3. Next period onward is 4/2 with no glitch or short period.
- Channel 2 oneshot=1, period=6, width=6, start strobe → pulse[2] and busy[2] high exactly 6 cycles, tick[2] on the 6th. Extra start at cycle 3 is ignored. Start the cycle after completion triggers a second 6-cycle shot.
- Boundary values on channel 3: period=0 → pulse every cycle (Pe=1, width≥1 constant high, tick constant 1). width=0 → pulse never high while tick still fires. width=10 with period=4 → pulse constant high.
- Assert reset mid-period on all channels while running → all outputs 0 the next cycle. After reset release, channels stay IDLE until enable/start.
- All 4 channels running different configs simultaneously; drop enable[1] mid-period → only channel 1 stops, next cycle. Other channels' pulse/tick timing is unchanged cycle-for-cycle versus a reference model.
